// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing the async FIFO write port among NREQ wclk-domain requesters.
// Optional owner-stall counter is built when WR_ARB_STALL_CNT_EN is defined.
module fifo_wr_arbiter #(
    parameter int NREQ     = 4,
    parameter int DSIZE    = 8,
    parameter int MAXBURST = 4
) (
    input  logic                  wclk,
    input  logic                  wrst_n,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*DSIZE-1:0] req_data,
    input  logic [NREQ-1:0]       req_last,
    input  logic                  wfull,
    output logic [NREQ-1:0]       gnt,
    output logic [NREQ-1:0]       ack,
    output logic                  winc,
    output logic [DSIZE-1:0]      wdata,
    output logic                  busy,
    output logic [15:0]           stall_cnt
);

    localparam int OW = $clog2(NREQ);
    localparam int BW = $clog2(MAXBURST) + 1;
    localparam logic [BW-1:0]   BEAT_LAST = BW'(MAXBURST - 1);
    localparam logic [OW-1:0]   OWN_MAX   = OW'(NREQ - 1);
    localparam logic [NREQ-1:0] ONE       = NREQ'(1);

    typedef enum logic {IDLE, BURST} state_t;

    state_t          state_q, state_d;
    logic [OW-1:0]   owner_q, owner_d;
    logic [OW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [BW-1:0]   beat_q, beat_d;
    logic [NREQ-1:0] gnt_d;
    logic [OW-1:0]   pick;
    logic            accept;

    // Round-robin search starting at rr_ptr, wrapping at NREQ (non-power-of-2 safe)
    always_comb begin
        int            idx;
        logic          found;
        logic [OW-1:0] cand;
        idx   = 0;
        found = 1'b0;
        cand  = '0;
        pick  = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(rr_ptr_q) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            cand = idx[OW-1:0];
            if (!found && req[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        rr_ptr_d = rr_ptr_q;
        beat_d   = beat_q;
        gnt_d    = gnt;
        accept   = 1'b0;
        ack      = '0;
        winc     = 1'b0;
        wdata    = '0;
        case (state_q)
            IDLE: begin
                if (|req) begin
                    owner_d = pick;
                    gnt_d   = ONE << pick;
                    beat_d  = '0;
                    state_d = BURST;
                end else begin
                    gnt_d = '0;
                end
            end
            BURST: begin
                wdata  = req_data[owner_q*DSIZE +: DSIZE];
                accept = req[owner_q] & ~wfull;
                if (accept) begin
                    ack    = ONE << owner_q;
                    winc   = 1'b1;
                    beat_d = beat_q + 1'b1;
                end
                // A full FIFO holds the grant; only withdrawal, last word or burst limit rotate
                if (!req[owner_q] || (accept && (req_last[owner_q] || beat_q == BEAT_LAST))) begin
                    state_d  = IDLE;
                    rr_ptr_d = (owner_q == OWN_MAX) ? '0 : owner_q + 1'b1;
                    gnt_d    = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge wclk) begin
        if (!wrst_n) begin
            state_q  <= IDLE;
            owner_q  <= '0;
            rr_ptr_q <= '0;
            beat_q   <= '0;
            gnt      <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            rr_ptr_q <= rr_ptr_d;
            beat_q   <= beat_d;
            gnt      <= gnt_d;
        end
    end

    assign busy = (state_q == BURST);

`ifdef WR_ARB_STALL_CNT_EN
    logic [15:0] stall_q;

    always_ff @(posedge wclk) begin
        if (!wrst_n) begin
            stall_q <= '0;
        end else if (state_q == BURST && req[owner_q] && wfull && stall_q != 16'hFFFF) begin
            stall_q <= stall_q + 16'd1;
        end
    end

    assign stall_cnt = stall_q;
`else
    assign stall_cnt = 16'h0000;
`endif

endmodule
